sram_stream_reader: RTL



---
 rtl/sram_stream_reader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sram_stream_reader.sv
// ----------------------------------------------------------------------------
// sram_stream_reader
//
// Read-side client for a simple dual-port SRAM with a registered read address
// (read data appears one cycle after the address). On a start command it walks
// base_addr .. base_addr+length-1 (wrapping modulo 2^ADDR_WIDTH), issues at
// most one read per cycle and delivers the returned words on a valid/ready
// stream with a last flag. A 2-entry output buffer absorbs the SRAM latency so
// that full throughput is kept with out_ready held high, and reads stall when
// the consumer applies backpressure.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   command strobe, only honoured while idle
//   base_addr  in   first SRAM address of the command
//   length     in   number of words (0 .. 2^ADDR_WIDTH)
//   busy       out  command active (READ, DRAIN, FIN)
//   done       out  one-cycle completion pulse
//   rd_addr    out  SRAM read address
//   rd_data    in   SRAM read data for the previous cycle's rd_addr
//   out_data   out  stream data (buffer head)
//   out_valid  out  stream valid
//   out_ready  in   stream ready from the consumer
//   out_last   out  final word of the command
// ----------------------------------------------------------------------------
module sram_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic                  buf_last_q [2];
    logic                  buf_last_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            buf_count_q, buf_count_d;

    logic                  pop;
    logic                  issue;
    logic                  issue_last;
    logic [2:0]            occupancy;

    // Stream side is read straight from the buffer head; the last flag is
    // masked with valid so it reads 0 whenever the buffer is empty.
    assign out_valid = (buf_count_q != 2'd0);
    assign out_data  = buf_data_q[rd_ptr_q];
    assign out_last  = out_valid & buf_last_q[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign pop       = out_valid & out_ready;

    // Occupancy the buffer will have after this cycle if no new read is
    // issued: words already buffered plus the word returning from the SRAM,
    // minus the one being popped. A read is only issued while this is below
    // two, which guarantees a free slot when its data returns next cycle.
    assign occupancy  = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == READ) && (occupancy < 3'd2) && (issued_q != len_q);
    assign issue_last = (issued_q == (len_q - LEN_ONE));

    // The address must be presented in the same cycle the issue decision is
    // made (it depends on this cycle's pop), so it is muxed against the held
    // copy of the last issued address.
    assign rd_addr = issue ? (base_q + issued_q[ADDR_WIDTH-1:0]) : rd_addr_q;

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        len_d           = len_q;
        issued_d        = issued_q;
        rd_addr_d       = rd_addr;
        inflight_d      = issue;
        inflight_last_d = issue & issue_last;
        buf_data_d      = buf_data_q;
        buf_last_d      = buf_last_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        buf_count_d     = occupancy[1:0];

        if (issue) begin
            issued_d = issued_q + LEN_ONE;
        end

        // Data returning from last cycle's read lands in the tail slot,
        // tagged with whether it was the final word of the command.
        if (inflight_q) begin
            buf_data_d[wr_ptr_q] = rd_data;
            buf_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    issued_d = LEN_ZERO;
                    state_d  = (length == LEN_ZERO) ? FIN : READ;
                end
            end
            READ: begin
                if (issue && issue_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = FIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            base_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            rd_addr_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q      <= '{default: '0};
            buf_last_q      <= '{default: 1'b0};
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            buf_count_q     <= 2'd0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            rd_addr_q       <= rd_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            buf_data_q      <= buf_data_d;
            buf_last_q      <= buf_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            buf_count_q     <= buf_count_d;
        end
    end

endmodule
